imem_dmem_arbiter: RTL and testbench



---
 rtl/imem_dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbiter that shares one synchronous-read memory between the fetch port and the load/store port.
// Define ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module imem_dmem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StCapture, StDone} state_t;

    state_t      state;
    logic        own_d;
    logic        own_wen;
    logic        own_rej;
    logic        grant_d;
    logic [31:0] sel_addr;
    logic        sel_rej;
`ifdef ARB_RR_EN
    logic        last_d;
`endif

    assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

    always_comb begin
        grant_d = d_req;
`ifdef ARB_RR_EN
        // On contention the port that was not granted most recently wins.
        if (d_req && i_req) begin
            grant_d = ~last_d;
        end
`endif
    end

    assign sel_addr = grant_d ? d_addr : i_addr;
    // Misaligned or beyond the memory's word range: walk the FSM but never touch memory.
    assign sel_rej  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= StIdle;
            own_d     <= 1'b0;
            own_wen   <= 1'b0;
            own_rej   <= 1'b0;
            mem_en    <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
`ifdef ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            i_err <= 1'b0;
            d_err <= 1'b0;
            case (state)
                StIdle: begin
                    if (i_req || d_req) begin
                        state     <= StAccess;
                        own_d     <= grant_d;
                        own_wen   <= grant_d & d_wen;
                        own_rej   <= sel_rej;
                        mem_en    <= ~sel_rej;
                        mem_wen   <= grant_d & d_wen & ~sel_rej;
                        mem_addr  <= sel_addr[ADDR_W+1:2];
                        mem_wdata <= d_wdata;
`ifdef ARB_RR_EN
                        last_d    <= grant_d;
`endif
                    end
                end
                StAccess: begin
                    state   <= StCapture;
                    mem_en  <= 1'b0;
                    mem_wen <= 1'b0;
                end
                StCapture: begin
                    state <= StDone;
                    if (own_d) begin
                        d_ack <= 1'b1;
                        d_err <= own_rej;
                        if (!own_wen && !own_rej) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        i_ack <= 1'b1;
                        i_err <= own_rej;
                        if (!own_rej) begin
                            i_rdata <= mem_rdata;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model (honours ARB_RR_EN when defined).
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic        i_req, d_req, d_wen;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, i_err, d_err, stall;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en, mem_wen;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        pre_we = 1'b0;
    logic [7:0]  pre_addr = 8'd0;
    logic [31:0] pre_data = 32'd0;
    logic [31:0] mem [0:255];

    int          tests = 0;
    int          fails = 0;

    // Transaction-level reference state
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_ird, exp_drd;
    bit          rr_last_d;

    imem_dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .clr(clr),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .stall(stall),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory device: synchronous read, plus a bench-only preload port
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_wen) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        ref_mem[a] = v;
        step();
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1; i_req = 1'b0; d_req = 1'b0;
        step(); step();
        clr = 1'b0;
        exp_ird = 32'd0; exp_drd = 32'd0; rr_last_d = 1'b0;
    endtask

    // Applies one completed access to the reference state; returns 1 if it is rejected.
    function automatic bit model_access(input bit is_d, input bit wen, input logic [31:0] addr,
                                        input logic [31:0] wdata);
        bit bad;
        bad = (addr[1:0] != 2'b00) || (addr >= 32'h400);
        if (!bad) begin
            if (is_d && wen) ref_mem[addr[9:2]] = wdata;
            else if (is_d) exp_drd = ref_mem[addr[9:2]];
            else exp_ird = ref_mem[addr[9:2]];
        end
        rr_last_d = is_d;
        return bad;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        if (r == 1) return 32'h400 | {22'($urandom), 10'd0};
        return {22'd0, 8'($urandom), 2'b00};
    endfunction

    task automatic test_reset();
        clr = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        step(); step();
        @(negedge clk);
        tests++;
        if ({i_ack, d_ack, i_err, d_err, mem_en, mem_wen} !== 6'd0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000000", {i_ack, d_ack, i_err, d_err, mem_en, mem_wen});
        end
        tests++;
        if (mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
            fails++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        tests++;
        if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            fails++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata);
        end
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall_idle: got %b want 0", stall); end
        step();
        i_req = 1'b1;
        @(negedge clk);
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL reset_stall_clr: got %b want 1", stall); end
        step();
        i_req = 1'b0;
        step();
        clr = 1'b0;
        exp_ird = 32'd0; exp_drd = 32'd0; rr_last_d = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        bit bad;
        preload(8'd3, 32'h8C22_0004);
        bad = model_access(1'b0, 1'b0, 32'h0000_000C, 32'd0);
        i_req = 1'b1; i_addr = 32'h0000_000C;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (stall !== (c < 3)) begin fails++; $display("FAIL fetch_stall c%0d: got %b want %b", c, stall, c < 3); end
            tests++;
            if (i_ack !== (c == 3)) begin fails++; $display("FAIL fetch_ack c%0d: got %b want %b", c, i_ack, c == 3); end
            tests++;
            if (mem_en !== (c == 1)) begin fails++; $display("FAIL fetch_en c%0d: got %b want %b", c, mem_en, c == 1); end
            if (c == 1) begin
                tests++;
                if (mem_addr !== 8'd3) begin fails++; $display("FAIL fetch_maddr: got %h want 03", mem_addr); end
            end
            if (c == 3) begin
                tests++;
                if (i_rdata !== 32'h8C22_0004 || i_err !== bad) begin
                    fails++; $display("FAIL fetch_data: got %h err %b want 8c220004 err 0", i_rdata, i_err);
                end
            end
            step();
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_store_load();
        bit bad;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] old_drd;
            old_drd = exp_drd;
            d_req = 1'b1; d_wen = (k == 0); d_addr = 32'h40; d_wdata = (k == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
            bad = model_access(1'b1, k == 0, 32'h40, 32'hDEAD_BEEF);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                tests++;
                if (d_ack !== (c == 3)) begin fails++; $display("FAIL sl%0d_ack c%0d: got %b want %b", k, c, d_ack, c == 3); end
                if (c == 1) begin
                    tests++;
                    if (mem_en !== 1'b1 || mem_wen !== (k == 0) || mem_addr !== 8'h10) begin
                        fails++; $display("FAIL sl%0d_bus: got en %b wen %b addr %h want 1 %b 10", k, mem_en, mem_wen, mem_addr, k == 0);
                    end
                end
                if (c == 3) begin
                    tests++;
                    if (d_err !== 1'b0) begin fails++; $display("FAIL sl%0d_err: got %b want 0", k, d_err); end
                    tests++;
                    if (d_rdata !== ((k == 0) ? old_drd : 32'hDEAD_BEEF)) begin
                        fails++; $display("FAIL sl%0d_rdata: got %h want %h", k, d_rdata, (k == 0) ? old_drd : 32'hDEAD_BEEF);
                    end
                end
                step();
            end
            d_req = 1'b0;
            step();
        end
    endtask

    task automatic test_contention();
        bit bad;
        do_reset();
        step();
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h40; i_req = 1'b1; i_addr = 32'h10;
        bad = model_access(1'b1, 1'b0, 32'h40, 32'd0);
        bad = model_access(1'b0, 1'b0, 32'h10, 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests++;
            if (d_ack !== (c == 3) || i_ack !== (c == 7)) begin
                fails++; $display("FAIL cont_acks c%0d: got d%b i%b want d%b i%b", c, d_ack, i_ack, c == 3, c == 7);
            end
            tests++;
            if (stall !== (c != 7)) begin fails++; $display("FAIL cont_stall c%0d: got %b want %b", c, stall, c != 7); end
            if (c == 3) begin
                tests++;
                if (d_rdata !== exp_drd) begin fails++; $display("FAIL cont_drdata: got %h want %h", d_rdata, exp_drd); end
            end
            if (c == 7) begin
                tests++;
                if (i_rdata !== exp_ird) begin fails++; $display("FAIL cont_irdata: got %h want %h", i_rdata, exp_ird); end
            end
            step();
            if (c == 3) d_req = 1'b0;
        end
        i_req = 1'b0;
        step();
`ifdef ARB_RR_EN
        d_req = 1'b1; d_addr = 32'h44; i_req = 1'b1; i_addr = 32'h14;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            tests++;
            if (d_ack !== (c % 8 == 3) || i_ack !== (c % 8 == 7)) begin
                fails++; $display("FAIL rr_acks c%0d: got d%b i%b want d%b i%b", c, d_ack, i_ack, c % 8 == 3, c % 8 == 7);
            end
            step();
        end
        d_req = 1'b0; i_req = 1'b0;
        bad = model_access(1'b1, 1'b0, 32'h44, 32'd0);
        bad = model_access(1'b0, 1'b0, 32'h14, 32'd0);
        step();
        tests++;
        if (d_rdata !== exp_drd || i_rdata !== exp_ird) begin
            fails++; $display("FAIL rr_rdata: got %h/%h want %h/%h", d_rdata, i_rdata, exp_drd, exp_ird);
        end
`endif
    endtask

    task automatic test_reject();
        bit bad;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h42; end
            else begin i_req = 1'b1; i_addr = 32'h400; end
            bad = model_access(k == 0, 1'b0, (k == 0) ? 32'h42 : 32'h400, 32'd0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                tests++;
                if (mem_en !== 1'b0) begin fails++; $display("FAIL rej%0d_en c%0d: got %b want 0", k, c, mem_en); end
                if (c == 3) begin
                    tests++;
                    if (k == 0 && (d_ack !== 1'b1 || d_err !== bad || d_rdata !== exp_drd)) begin
                        fails++; $display("FAIL rej_d: got ack %b err %b rd %h want 1 1 %h", d_ack, d_err, d_rdata, exp_drd);
                    end
                    if (k == 1 && (i_ack !== 1'b1 || i_err !== bad || i_rdata !== exp_ird)) begin
                        fails++; $display("FAIL rej_i: got ack %b err %b rd %h want 1 1 %h", i_ack, i_err, i_rdata, exp_ird);
                    end
                end
                step();
            end
            d_req = 1'b0; i_req = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        i_req = 1'b1; i_addr = 32'h20;
        step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        exp_ird = 32'd0; exp_drd = 32'd0; rr_last_d = 1'b0;
        bad = model_access(1'b0, 1'b0, 32'h20, 32'd0);
        for (int c = 3; c < 7; c++) begin
            @(negedge clk);
            tests++;
            if (i_ack !== (c == 6)) begin fails++; $display("FAIL rmid_ack c%0d: got %b want %b", c, i_ack, c == 6); end
            tests++;
            if (mem_en !== (c == 4)) begin fails++; $display("FAIL rmid_en c%0d: got %b want %b", c, mem_en, c == 4); end
            if (c == 3) begin
                tests++;
                if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
                    fails++; $display("FAIL rmid_clr: got %h/%h want 0/0", i_rdata, d_rdata);
                end
            end
            if (c == 6) begin
                tests++;
                if (i_rdata !== exp_ird) begin fails++; $display("FAIL rmid_rdata: got %h want %h", i_rdata, exp_ird); end
            end
            step();
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        bit bad;
        i_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_addr = 32'(4 * (c / 4));
            if (c % 4 == 0) bad = model_access(1'b0, 1'b0, i_addr, 32'd0);
            @(negedge clk);
            tests++;
            if (i_ack !== (c % 4 == 3) || stall !== (c % 4 != 3)) begin
                fails++; $display("FAIL b2b c%0d: got ack %b stall %b want %b %b", c, i_ack, stall, c % 4 == 3, c % 4 != 3);
            end
            if (c % 4 == 3) begin
                tests++;
                if (i_rdata !== exp_ird) begin fails++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, i_rdata, exp_ird); end
            end
            step();
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int unsigned mode;
            bit use_i, use_d, dw, d_first, bad_first, bad_second, bad;
            logic [31:0] ia, da, wd;
            int i_at, d_at, last;
            mode = $urandom_range(0, 2);
            use_i = (mode != 1); use_d = (mode != 0);
            ia = rand_addr(); da = rand_addr(); dw = 1'($urandom); wd = $urandom;
            i_at = -1; d_at = -1;
            d_first = use_d;
            if (use_i && use_d) begin
`ifdef ARB_RR_EN
                d_first = !rr_last_d;
`else
                d_first = 1'b1;
`endif
            end
            bad_first = model_access(d_first, dw, d_first ? da : ia, wd);
            if (d_first) d_at = 3; else i_at = 3;
            bad_second = 1'b0;
            if (use_i && use_d) begin
                bad_second = model_access(!d_first, dw, d_first ? ia : da, wd);
                if (d_first) i_at = 7; else d_at = 7;
            end
            bad = d_first ? bad_first : bad_second;
            last = (i_at > d_at) ? i_at : d_at;
            i_req = use_i; i_addr = ia; d_req = use_d; d_wen = dw; d_addr = da; d_wdata = wd;
            for (int c = 0; c <= last; c++) begin
                @(negedge clk);
                tests++;
                if (i_ack !== (c == i_at) || d_ack !== (c == d_at)) begin
                    fails++; $display("FAIL rnd%0d_ack c%0d: got i%b d%b want i%b d%b", it, c, i_ack, d_ack, c == i_at, c == d_at);
                end
                tests++;
                if (stall !== ((i_req && c != i_at) || (d_req && c != d_at))) begin
                    fails++; $display("FAIL rnd%0d_stall c%0d: got %b", it, c, stall);
                end
                tests++;
                if (mem_en !== ((c == 1 && !bad_first) || (c == 5 && last == 7 && !bad_second))) begin
                    fails++; $display("FAIL rnd%0d_en c%0d: got %b", it, c, mem_en);
                end
                if (c == d_at) begin
                    tests++;
                    if (d_err !== bad || d_rdata !== exp_drd) begin
                        fails++; $display("FAIL rnd%0d_d: got err %b rd %h want %b %h", it, d_err, d_rdata, bad, exp_drd);
                    end
                end
                if (c == i_at) begin
                    tests++;
                    if (i_err !== (d_first ? bad_second : bad_first) || i_rdata !== exp_ird) begin
                        fails++; $display("FAIL rnd%0d_i: got err %b rd %h want %h", it, i_err, i_rdata, exp_ird);
                    end
                end
                step();
                if (c == i_at) i_req = 1'b0;
                if (c == d_at) d_req = 1'b0;
            end
            step();
            tests++;
            if (i_rdata !== exp_ird || d_rdata !== exp_drd) begin
                fails++; $display("FAIL rnd%0d_hold: got %h/%h want %h/%h", it, i_rdata, d_rdata, exp_ird, exp_drd);
            end
        end
    endtask

    initial begin
        test_reset();
        for (int a = 0; a < 256; a++) preload(8'(a), $urandom);
        test_fetch();
        test_store_load();
        test_contention();
        test_reject();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
